// File: rtl/codma_if.sv
// Host-port and command bundle for the copy-DMA block.
// The checksum_o wire is present only when CODMA_CHECKSUM_EN is defined.
interface codma_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              mem_wr_en_i;
  logic [ADDR_W-1:0] mem_addr_i;
  logic [DATA_W-1:0] mem_wdata_i;
  logic [DATA_W-1:0] mem_rdata_o;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [ADDR_W-1:0] cmd_src_i;
  logic [ADDR_W-1:0] cmd_dst_i;
  logic [ADDR_W:0]   cmd_len_i;
  logic              busy_o;
  logic              done_o;
`ifdef CODMA_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_o;
`endif

  modport master (
    output mem_wr_en_i, mem_addr_i, mem_wdata_i,
    output cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i,
    input  mem_rdata_o, cmd_ready_o, busy_o,
`ifdef CODMA_CHECKSUM_EN
    input  checksum_o,
`endif
    input  done_o
  );

  modport slave (
    input  mem_wr_en_i, mem_addr_i, mem_wdata_i,
    input  cmd_valid_i, cmd_src_i, cmd_dst_i, cmd_len_i,
    output mem_rdata_o, cmd_ready_o, busy_o,
`ifdef CODMA_CHECKSUM_EN
    output checksum_o,
`endif
    output done_o
  );
endinterface

// File: rtl/codma_top.sv
// Copy-DMA: single-port word memory plus a READ/WRITE engine copying blocks inside it.
// Optional running XOR checksum of copied words, enabled by defining CODMA_CHECKSUM_EN.
module codma_top #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic     clk_i,
  input  logic     reset_n_i,
  codma_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] LEN_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W:0] LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};

  state_t            state_r;
  state_t            next_state_s;
  logic [ADDR_W-1:0] src_r;
  logic [ADDR_W-1:0] dst_r;
  logic [ADDR_W:0]   len_r;
  logic [ADDR_W:0]   cnt_r;
  logic [ADDR_W:0]   cnt_inc_s;
  logic [DATA_W-1:0] word_r;
  logic [DATA_W-1:0] rdata_r;
  logic              ready_r;
  logic              busy_r;
  logic              done_r;
  logic              accept_s;
  logic [ADDR_W-1:0] rd_addr_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_waddr_s;
  logic [DATA_W-1:0] mem_wdata_s;
  logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];
`ifdef CODMA_CHECKSUM_EN
  logic [DATA_W-1:0] checksum_r;
`endif

  // Address arithmetic truncates to ADDR_W bits, so both pointers wrap naturally.
  assign accept_s  = (state_r == IDLE) && bus.cmd_valid_i;
  assign rd_addr_s = src_r + cnt_r[ADDR_W-1:0];

  // Next-state decode of the copy engine.
  always_comb begin
    next_state_s = state_r;
    cnt_inc_s    = cnt_r + LEN_ONE;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          next_state_s = (bus.cmd_len_i == LEN_ZERO) ? DONE : READ;
        end else begin
          next_state_s = IDLE;
        end
      end
      READ:  next_state_s = WRITE;
      WRITE: begin
        if (cnt_inc_s == len_r) begin
          next_state_s = DONE;
        end else begin
          next_state_s = READ;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Single write port shared between host (IDLE) and engine (WRITE).
  always_comb begin
    mem_we_s    = 1'b0;
    mem_waddr_s = bus.mem_addr_i;
    mem_wdata_s = bus.mem_wdata_i;
    if (state_r == IDLE) begin
      mem_we_s = bus.mem_wr_en_i;
    end else if (state_r == WRITE) begin
      mem_we_s    = 1'b1;
      mem_waddr_s = dst_r + cnt_r[ADDR_W-1:0];
      mem_wdata_s = word_r;
    end else begin
      mem_we_s = 1'b0;
    end
  end

  // Memory array: never reset, writes blocked while reset is held.
  always_ff @(posedge clk_i) begin
    if (reset_n_i && mem_we_s) begin
      mem_r[mem_waddr_s] <= mem_wdata_s;
    end
  end

  // Engine state, command latches and registered outputs.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r <= IDLE;
      src_r   <= {ADDR_W{1'b0}};
      dst_r   <= {ADDR_W{1'b0}};
      len_r   <= LEN_ZERO;
      cnt_r   <= LEN_ZERO;
      word_r  <= {DATA_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      ready_r <= (next_state_s == IDLE);
      busy_r  <= (next_state_s != IDLE);
      done_r  <= (next_state_s == DONE);
      if (state_r == IDLE) begin
        rdata_r <= mem_r[bus.mem_addr_i];
      end
      if (accept_s) begin
        src_r <= bus.cmd_src_i;
        dst_r <= bus.cmd_dst_i;
        len_r <= bus.cmd_len_i;
        cnt_r <= LEN_ZERO;
      end
      if (state_r == READ) begin
        word_r <= mem_r[rd_addr_s];
      end
      if (state_r == WRITE) begin
        cnt_r <= cnt_inc_s;
      end
    end
  end

`ifdef CODMA_CHECKSUM_EN
  // Running XOR of copied words; cleared on acceptance, held otherwise.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if (accept_s) begin
      checksum_r <= {DATA_W{1'b0}};
    end else if (state_r == WRITE) begin
      checksum_r <= checksum_r ^ word_r;
    end
  end

  assign bus.checksum_o = checksum_r;
`endif

  assign bus.mem_rdata_o = rdata_r;
  assign bus.cmd_ready_o = ready_r;
  assign bus.busy_o      = busy_r;
  assign bus.done_o      = done_r;

endmodule

// File: tb/tb_codma_top.sv
// Scoreboard bench for codma_top: stimulus pushes expected host-read data and
// done timing/checksum into queues; a negedge monitor pops and compares.
module tb_codma_top;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
  } rd_exp_t;

  typedef struct {
    int          cyc;
    logic [31:0] cs;
  } done_exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;
  logic rd_req = 1'b0;
  logic rd_vld = 1'b0;
  rd_exp_t   rd_q[$];
  done_exp_t done_q[$];

  codma_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  codma_top #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk_i     (clk),
    .reset_n_i (reset_n),
    .bus       (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_vld <= rd_req;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Monitor: compares whenever the DUT presents read data or a done pulse.
  always @(negedge clk) begin
    if (rd_vld) begin
      if (rd_q.size() == 0) begin
        check("rd_unexpected", 32'd1, 32'd0);
      end else begin
        rd_exp_t e;
        e = rd_q.pop_front();
        check($sformatf("rdata[%h]", e.addr), bus.mem_rdata_o, e.data);
      end
    end
    if (bus.done_o) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 32'd1, 32'd0);
      end else begin
        done_exp_t d;
        d = done_q.pop_front();
        check("done_cycle", cyc, d.cyc);
`ifdef CODMA_CHECKSUM_EN
        check("checksum", bus.checksum_o, d.cs);
`endif
      end
    end
  end

  task automatic host_write(input logic [7:0] a, input logic [31:0] d);
    bus.mem_wr_en_i = 1'b1;
    bus.mem_addr_i  = a;
    bus.mem_wdata_i = d;
    @(posedge clk); #1;
    bus.mem_wr_en_i = 1'b0;
  endtask

  task automatic host_read(input logic [7:0] a, input logic [31:0] exp);
    rd_exp_t e;
    e.addr = a;
    e.data = exp;
    rd_q.push_back(e);
    bus.mem_addr_i = a;
    rd_req = 1'b1;
    @(posedge clk); #1;
    rd_req = 1'b0;
  endtask

  task automatic issue_cmd(input logic [7:0] src, input logic [7:0] dst, input int len,
                           input logic [31:0] cs, input int pred, output int t_acc);
    bit ok = 1'b0;
    done_exp_t d;
    bus.cmd_src_i   = src;
    bus.cmd_dst_i   = dst;
    bus.cmd_len_i   = 9'(len);
    bus.cmd_valid_i = 1'b1;
    t_acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.cmd_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (ok) begin
      t_acc = cyc + 1;
      d.cyc = t_acc + 2 * len;
      d.cs  = cs;
      done_q.push_back(d);
      if (pred >= 0) check("accept_cycle", t_acc, pred);
    end else begin
      check("accept_timeout", 32'd0, 32'd1);
    end
    @(posedge clk); #1;
    bus.cmd_valid_i = 1'b0;
    if (ok) begin
      check("busy_after_accept", {31'd0, bus.busy_o}, 32'd1);
      check("ready_after_accept", {31'd0, bus.cmd_ready_o}, 32'd0);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      if (done_q.size() == 0) break;
    end
    if (done_q.size() != 0) begin
      check("done_timeout", 32'(done_q.size()), 32'd0);
      done_q.delete();
    end
  endtask

  initial begin
    int t1;
    int t2;
    int tr;
    bus.mem_wr_en_i = 1'b0;
    bus.mem_addr_i  = 8'd0;
    bus.mem_wdata_i = 32'd0;
    bus.cmd_valid_i = 1'b0;
    bus.cmd_src_i   = 8'd0;
    bus.cmd_dst_i   = 8'd0;
    bus.cmd_len_i   = 9'd0;

    #3 reset_n = 1'b0;
    #1;
    check("rst_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    check("rst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("rst_done", {31'd0, bus.done_o}, 32'd0);
    check("rst_rdata", bus.mem_rdata_o, 32'd0);
`ifdef CODMA_CHECKSUM_EN
    check("rst_checksum", bus.checksum_o, 32'd0);
`endif
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    // Host write then read.
    host_write(8'h05, 32'hDEADBEEF);
    host_read(8'h05, 32'hDEADBEEF);

    // Basic copy 0x10..0x13 -> 0x40..0x43.
    for (int i = 0; i < 4; i++) host_write(8'h10 + 8'(i), 32'(i + 1));
    issue_cmd(8'h10, 8'h40, 4, 32'h4, -1, t1);
    wait_done();
    for (int i = 0; i < 4; i++) host_read(8'h40 + 8'(i), 32'(i + 1));

    // Zero length: done right after acceptance, memory untouched.
    issue_cmd(8'h10, 8'h40, 0, 32'h0, -1, t1);
    wait_done();
    host_read(8'h40, 32'h1);

    // Wrapping source 0xFE, 0xFF, 0x00 -> 0x02..0x04.
    host_write(8'hFE, 32'h11);
    host_write(8'hFF, 32'h22);
    host_write(8'h00, 32'h44);
    issue_cmd(8'hFE, 8'h02, 3, 32'h77, -1, t1);
    wait_done();
    host_read(8'h02, 32'h11);
    host_read(8'h03, 32'h22);
    host_read(8'h04, 32'h44);

    // Overlapping forward copy smears the first word.
    host_write(8'h00, 32'hAAAA0001);
    host_write(8'h01, 32'hBBBB0002);
    host_write(8'h02, 32'hCCCC0003);
    host_write(8'h03, 32'hDDDD0004);
    issue_cmd(8'h00, 8'h01, 3, 32'hAAAA0001, -1, t1);
    wait_done();
    for (int i = 0; i < 4; i++) host_read(8'(i), 32'hAAAA0001);

    // Host write lockout and back-to-back command held while busy.
    host_write(8'h90, 32'h5A5A5A5A);
    for (int i = 0; i < 8; i++) host_write(8'h20 + 8'(i), 32'(1 << i));
    issue_cmd(8'h20, 8'h50, 8, 32'hFF, -1, t1);
    host_write(8'h90, 32'h12345678);
    host_write(8'h90, 32'h87654321);
    issue_cmd(8'h10, 8'h48, 2, 32'h3, t1 + 2 * 8 + 2, t2);
    wait_done();
    host_read(8'h90, 32'h5A5A5A5A);
    host_read(8'h50, 32'h01);
    host_read(8'h57, 32'h80);
    host_read(8'h48, 32'h1);
    host_read(8'h49, 32'h2);

    // Reset after two of eight words have been written.
    for (int i = 0; i < 8; i++) begin
      host_write(8'h60 + 8'(i), 32'hA0 + 32'(i));
      host_write(8'h70 + 8'(i), 32'hB0 + 32'(i));
    end
    issue_cmd(8'h60, 8'h70, 8, 32'h0, -1, tr);
    repeat (4) @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    done_q.delete();
    check("midrst_ready", {31'd0, bus.cmd_ready_o}, 32'd1);
    check("midrst_busy", {31'd0, bus.busy_o}, 32'd0);
    check("midrst_done", {31'd0, bus.done_o}, 32'd0);
    check("midrst_rdata", bus.mem_rdata_o, 32'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    host_read(8'h70, 32'hA0);
    host_read(8'h71, 32'hA1);
    host_read(8'h72, 32'hB2);
    host_read(8'h77, 32'hB7);

    repeat (3) @(posedge clk);
    if (rd_q.size() != 0) check("rd_pending", 32'(rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
